// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 read master among NUM_REQ requesters.
// Build macro DDR_ARB_PRIORITY0_EN gives requester 0 fixed absolute priority over the others.
module ddr_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 34,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                                M_AXI_ACLK,
  input  logic                                M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                  REQ_VALID,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  output logic [NUM_REQ-1:0]                  REQ_READY,
  output logic [NUM_REQ-1:0]                  RSP_VALID,
  output logic [AXI_DATA_WIDTH-1:0]           RSP_DATA,
  output logic [1:0]                          RSP_RESP,
  output logic [AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic                                M_AXI_ARVALID,
  input  logic                                M_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]             M_AXI_ARID,
  output logic [7:0]                          M_AXI_ARLEN,
  output logic [2:0]                          M_AXI_ARSIZE,
  output logic [1:0]                          M_AXI_ARBURST,
  output logic                                M_AXI_ARLOCK,
  output logic [3:0]                          M_AXI_ARCACHE,
  output logic [3:0]                          M_AXI_ARQOS,
  output logic [2:0]                          M_AXI_ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic                                M_AXI_RVALID,
  input  logic [1:0]                          M_AXI_RRESP,
  input  logic                                M_AXI_RLAST,
  output logic                                M_AXI_RREADY
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]                state_q,     state_d;
  logic [IDX_W-1:0]          ptr_q,       ptr_d;
  logic [IDX_W-1:0]          grant_q,     grant_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic                      arvalid_q,   arvalid_d;
  logic                      rready_q,    rready_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [1:0]                rsp_resp_q,  rsp_resp_d;

  logic                      win_found_s;
  logic [IDX_W-1:0]          win_idx_s;
  logic [IDX_W-1:0]          cand_idx_s;
  logic [AXI_ADDR_WIDTH-1:0] win_addr_s;
  logic                      rlast_unused;

  // RLAST carries no information for single-beat reads.
  assign rlast_unused = M_AXI_RLAST;

  // Winner search starts one past the last granted requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_idx_s  = '0;
`ifdef DDR_ARB_PRIORITY0_EN
    if (REQ_VALID[0]) begin
      win_found_s = 1'b1;
      win_idx_s   = '0;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        cand_idx_s = IDX_W'(1 + ((int'(ptr_q) - 1 + k) % (NUM_REQ - 1)));
        if (!win_found_s && REQ_VALID[cand_idx_s]) begin
          win_found_s = 1'b1;
          win_idx_s   = cand_idx_s;
        end else begin
        end
      end
    end
`else
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found_s && REQ_VALID[cand_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_idx_s;
      end else begin
      end
    end
`endif
  end

  // Address slice of the current winner.
  always_comb begin
    win_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        win_addr_s = REQ_ADDR[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      end else begin
      end
    end
  end

  // Grant is offered combinationally only while idle.
  always_comb begin
    if (state_q == ST_IDLE && win_found_s) begin
      REQ_READY = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    end else begin
      REQ_READY = '0;
    end
  end

  // Next-state logic; AR and R handshakes in the same cycle both apply.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d   = ST_BUSY;
          grant_d   = win_idx_s;
          araddr_d  = win_addr_s;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
`ifdef DDR_ARB_PRIORITY0_EN
          if (win_idx_s != '0) begin
            ptr_d = win_idx_s;
          end else begin
          end
`else
          ptr_d = win_idx_s;
`endif
        end else begin
        end
      end
      ST_BUSY: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
        end else begin
        end
        if (rready_q && M_AXI_RVALID) begin
          rsp_data_d  = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          rready_d    = 1'b0;
          state_d     = ST_IDLE;
        end else begin
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any outstanding read.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARID    = AXI_ID_WIDTH'(grant_q);
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'd6;
  assign M_AXI_ARBURST = 2'd1;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd2;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'b001;
  assign M_AXI_RREADY  = rready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_DATA      = rsp_data_q;
  assign RSP_RESP      = rsp_resp_q;

endmodule
